// File: rtl/icache_responder_pkg.sv
// rtl/icache_responder_pkg.sv - shared types and defaults for the instruction cache responder
//
// Purpose : address-split defaults, fetch/memory-side bundle structs and the
//           responder state enum shared by the cache RTL.
// Ports   : none (package).
package icache_responder_pkg;

    localparam int XLEN               = 32;
    localparam int NUM_LINES_DEF      = 16;
    localparam int WORDS_PER_LINE_DEF = 4;
    localparam int BYTE_OFF_W         = 2;
    localparam int TAG_W_DEF          = XLEN - $clog2(NUM_LINES_DEF)
                                        - $clog2(WORDS_PER_LINE_DEF) - BYTE_OFF_W;

    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] addr;
    } type_if2icache_s;

    typedef struct packed {
        logic            ack;
        logic [XLEN-1:0] r_data;
    } type_icache2if_s;

    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] addr;
    } type_icache2mem_s;

    typedef struct packed {
        logic            ack;
        logic [XLEN-1:0] r_data;
    } type_mem2icache_s;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        REFILL = 2'd2
    } type_icache_resp_state_e;

endpackage

// File: rtl/icache_responder_if.sv
// rtl/icache_responder_if.sv - fetch-side and memory-side bus bundle for the icache responder
//
// Purpose : groups the prefetch request/response, flush and refill burst signals.
// Ports   : slave modport  = cache side (receives fetches, issues refills)
//           master modport = environment side (prefetch stage + instruction memory)
interface icache_responder_if;
    import icache_responder_pkg::*;

    logic            if2icache_req_i;
    logic [XLEN-1:0] if2icache_addr_i;
    logic            icache_flush_i;
    logic            icache2if_ack_o;
    logic [XLEN-1:0] icache2if_r_data_o;
    logic            icache2mem_req_o;
    logic [XLEN-1:0] icache2mem_addr_o;
    logic            mem2icache_ack_i;
    logic [XLEN-1:0] mem2icache_r_data_i;

    modport slave (
        input  if2icache_req_i,
        input  if2icache_addr_i,
        input  icache_flush_i,
        output icache2if_ack_o,
        output icache2if_r_data_o,
        output icache2mem_req_o,
        output icache2mem_addr_o,
        input  mem2icache_ack_i,
        input  mem2icache_r_data_i
    );

    modport master (
        output if2icache_req_i,
        output if2icache_addr_i,
        output icache_flush_i,
        input  icache2if_ack_o,
        input  icache2if_r_data_o,
        input  icache2mem_req_o,
        input  icache2mem_addr_o,
        output mem2icache_ack_i,
        output mem2icache_r_data_i
    );

endinterface

// File: rtl/icache_responder_data_array.sv
// rtl/icache_responder_data_array.sv - word/tag/valid storage for the direct-mapped icache
//
// Purpose : NUM_LINES x WORDS_PER_LINE word flops with synchronous per-word write
//           and asynchronous read, plus per-line tag and valid with flash clear.
// Ports   : clk, rst_n      clock, synchronous active-low reset (valid bits only)
//           flush_i         clear every valid bit at the next edge
//           word_*          refill beat write (line index, word offset, data)
//           tag_*, valid_i  line install at the end of a burst
//           rd_*            combinational lookup (data word, tag, valid)
module icache_responder_data_array
    import icache_responder_pkg::*;
#(
    parameter int NUM_LINES      = NUM_LINES_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int TAG_W          = TAG_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush_i,
    input  logic                              word_we_i,
    input  logic [$clog2(NUM_LINES)-1:0]      word_idx_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] word_off_i,
    input  logic [XLEN-1:0]                   word_data_i,
    input  logic                              tag_we_i,
    input  logic [$clog2(NUM_LINES)-1:0]      tag_idx_i,
    input  logic [TAG_W-1:0]                  tag_i,
    input  logic                              valid_i,
    input  logic [$clog2(NUM_LINES)-1:0]      rd_idx_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_off_i,
    output logic [XLEN-1:0]                   rd_data_o,
    output logic [TAG_W-1:0]                  rd_tag_o,
    output logic                              rd_valid_o
);

    logic [XLEN-1:0]      data_q [NUM_LINES][WORDS_PER_LINE];
    logic [XLEN-1:0]      data_d [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;

    always_comb begin
        data_d = data_q;
        if (word_we_i) begin
            data_d[word_idx_i][word_off_i] = word_data_i;
        end
    end

    // The install write comes after the flash clear, so a flush landing on the
    // last beat still leaves the line invalid (the caller drives valid_i low).
    always_comb begin
        tag_d   = tag_q;
        valid_d = flush_i ? '0 : valid_q;
        if (tag_we_i) begin
            tag_d[tag_idx_i]   = tag_i;
            valid_d[tag_idx_i] = valid_i;
        end
    end

    // Data and tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache responder
//
// Purpose : answers word fetches from the prefetch stage; hits ack one cycle
//           after lookup, misses refill a whole line by a fixed-length burst.
// Ports   : clk, rst_n  clock, synchronous active-low reset
//           bus         icache_responder_if.slave (fetch req/addr/ack/r_data,
//                       flush pulse, refill req/addr, memory beat ack/data)
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int NUM_LINES      = NUM_LINES_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    icache_responder_if.slave bus
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = XLEN - IDX_W - OFF_W - BYTE_OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    type_if2icache_s  fetch;
    type_mem2icache_s mem_rsp;

    assign fetch.req      = bus.if2icache_req_i;
    assign fetch.addr     = bus.if2icache_addr_i;
    assign mem_rsp.ack    = bus.mem2icache_ack_i;
    assign mem_rsp.r_data = bus.mem2icache_r_data_i;

    // Byte-within-word bits play no part in an instruction word fetch.
    logic unused_byte_bits;
    assign unused_byte_bits = ^fetch.addr[BYTE_OFF_W-1:0];

    type_icache_resp_state_e state_q, state_d;
    logic [OFF_W-1:0]        beat_q, beat_d;
    logic                    flush_pend_q, flush_pend_d;
    type_icache2if_s         rsp_q, rsp_d;
    type_icache2mem_s        refill_q, refill_d;

    logic [OFF_W-1:0] lk_off;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] rf_idx;
    logic [TAG_W-1:0] rf_tag;
    logic [XLEN-1:0]  rd_data;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit;
    logic             beat_we;
    logic             last_beat;
    logic             line_valid;

    assign lk_off = fetch.addr[BYTE_OFF_W +: OFF_W];
    assign lk_idx = fetch.addr[BYTE_OFF_W + OFF_W +: IDX_W];
    assign lk_tag = fetch.addr[XLEN-1 -: TAG_W];

    // The line being refilled is identified by the latched burst base address.
    assign rf_idx = refill_q.addr[BYTE_OFF_W + OFF_W +: IDX_W];
    assign rf_tag = refill_q.addr[XLEN-1 -: TAG_W];

    assign hit       = rd_valid && (rd_tag == lk_tag);
    assign beat_we   = (state_q == REFILL) && mem_rsp.ack;
    assign last_beat = beat_we && (beat_q == LAST_BEAT);

    // A flush seen at any point of the burst, including its final beat,
    // leaves the freshly written line invalid.
    assign line_valid = ~(flush_pend_q | bus.icache_flush_i);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        rsp_d        = rsp_q;
        rsp_d.ack    = 1'b0;
        refill_d     = refill_q;

        case (state_q)
            IDLE: begin
                if (fetch.req) begin
                    if (hit) begin
                        rsp_d.ack    = 1'b1;
                        rsp_d.r_data = rd_data;
                        state_d      = RESP;
                    end else begin
                        refill_d.req  = 1'b1;
                        refill_d.addr = {fetch.addr[XLEN-1:BYTE_OFF_W + OFF_W],
                                         {(BYTE_OFF_W + OFF_W){1'b0}}};
                        state_d       = REFILL;
                    end
                end
            end

            // The ack is on the bus this cycle; skipping the lookup keeps a
            // still-held request from being answered twice.
            RESP: begin
                state_d = IDLE;
            end

            REFILL: begin
                if (bus.icache_flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (beat_we) begin
                    beat_d = beat_q + 1'b1;
                end
                if (last_beat) begin
                    beat_d       = '0;
                    flush_pend_d = 1'b0;
                    refill_d.req = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            rsp_q        <= '0;
            refill_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            rsp_q        <= rsp_d;
            refill_q     <= refill_d;
        end
    end

    icache_responder_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_data_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (bus.icache_flush_i),
        .word_we_i   (beat_we),
        .word_idx_i  (rf_idx),
        .word_off_i  (beat_q),
        .word_data_i (mem_rsp.r_data),
        .tag_we_i    (last_beat),
        .tag_idx_i   (rf_idx),
        .tag_i       (rf_tag),
        .valid_i     (line_valid),
        .rd_idx_i    (lk_idx),
        .rd_off_i    (lk_off),
        .rd_data_o   (rd_data),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid)
    );

    assign bus.icache2if_ack_o    = rsp_q.ack;
    assign bus.icache2if_r_data_o = rsp_q.r_data;
    assign bus.icache2mem_req_o   = refill_q.req;
    assign bus.icache2mem_addr_o  = refill_q.addr;

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - self-checking bench for icache_responder
module tb_icache_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_responder_if bus ();

    icache_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: which memory line each of the 16 cache slots holds, if any.
    bit          m_valid [16];
    int unsigned m_tag   [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction memory contents: the 0x1000 line carries 0xA0..0xA3.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if ((a >> 4) == 32'h100) return 32'hA0 + ((a >> 2) & 32'h3);
        return (a & 32'hFFFF_FFFC) ^ 32'h5A5A_0000;
    endfunction

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 4) & 32'hF);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_tag[slot(a)] == 32'(a >> 8));
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_install(input logic [31:0] a);
        m_valid[slot(a)] = 1'b1;
        m_tag[slot(a)]   = 32'(a >> 8);
    endtask

    // Issues a fetch and plays the memory side until it is answered or withdrawn.
    // flush_beat / drop_beat: beat index on which to pulse flush / drop req (-1 = never).
    task automatic fetch(input logic [31:0] a, input int flush_beat, input int drop_beat,
                         input bit gaps, input bit flush_at_lookup);
        bit          hit;
        bit          flushed;
        bit          done;
        bit          go;
        int          beats;
        int          budget;
        logic [31:0] base;
        base = a & 32'hFFFF_FFF0;
        bus.if2icache_req_i  = 1'b1;
        bus.if2icache_addr_i = a;
        done = 1'b0;
        for (int att = 0; att < 3 && !done; att++) begin
            hit = model_hit(a);
            if (att == 0 && flush_at_lookup) bus.icache_flush_i = 1'b1;
            @(negedge clk);
            bus.icache_flush_i = 1'b0;
            if (att == 0 && flush_at_lookup) model_flush();
            if (hit) begin
                chk("hit_ack", 32'(bus.icache2if_ack_o), 32'd1);
                chk("hit_data", bus.icache2if_r_data_o, mem_val(a));
                chk("hit_no_mem_req", 32'(bus.icache2mem_req_o), 32'd0);
                bus.if2icache_req_i = 1'b0;
                @(negedge clk);
                chk("single_ack", 32'(bus.icache2if_ack_o), 32'd0);
                done = 1'b1;
            end else begin
                chk("miss_no_ack", 32'(bus.icache2if_ack_o), 32'd0);
                chk("miss_mem_req", 32'(bus.icache2mem_req_o), 32'd1);
                chk("miss_base", bus.icache2mem_addr_o, base);
                beats   = 0;
                budget  = 0;
                flushed = 1'b0;
                while (beats < 4 && budget < 64) begin
                    go = !gaps || ($urandom_range(3) != 0);
                    bus.mem2icache_ack_i    = go;
                    bus.mem2icache_r_data_i = go ? mem_val(base + 32'(4 * beats)) : $urandom;
                    if (go && att == 0 && beats == flush_beat) begin
                        bus.icache_flush_i = 1'b1;
                        flushed = 1'b1;
                    end
                    if (go && att == 0 && beats == drop_beat) bus.if2icache_req_i = 1'b0;
                    if (go) beats++;
                    budget++;
                    @(negedge clk);
                    bus.icache_flush_i   = 1'b0;
                    bus.mem2icache_ack_i = 1'b0;
                    chk("burst_no_ack", 32'(bus.icache2if_ack_o), 32'd0);
                    if (beats < 4) begin
                        chk("burst_req_held", 32'(bus.icache2mem_req_o), 32'd1);
                        chk("burst_addr_held", bus.icache2mem_addr_o, base);
                    end
                end
                if (beats < 4) chk("burst_timeout", 32'(beats), 32'd4);
                chk("mem_req_drop", 32'(bus.icache2mem_req_o), 32'd0);
                if (flushed) model_flush();
                else model_install(a);
                if (!bus.if2icache_req_i) done = 1'b1;
            end
        end
        if (!done) chk("fetch_unanswered", 32'd0, 32'd1);
        bus.if2icache_req_i = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        int          fb;
        int          db;

        rst_n                   = 1'b0;
        bus.if2icache_req_i     = 1'b0;
        bus.if2icache_addr_i    = '0;
        bus.icache_flush_i      = 1'b0;
        bus.mem2icache_ack_i    = 1'b0;
        bus.mem2icache_r_data_i = '0;
        model_flush();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.icache2if_ack_o), 32'd0);
        chk("rst_r_data", bus.icache2if_r_data_o, 32'd0);
        chk("rst_mem_req", 32'(bus.icache2mem_req_o), 32'd0);
        chk("rst_mem_addr", bus.icache2mem_addr_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, back-to-back beats.
        fetch(32'h0000_1004, -1, -1, 1'b0, 1'b0);

        // Held hit: acks alternate, never on consecutive cycles.
        bus.if2icache_req_i  = 1'b1;
        bus.if2icache_addr_i = 32'h0000_100C;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("held_ack", 32'(bus.icache2if_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) chk("held_data", bus.icache2if_r_data_o, 32'h0000_00A3);
            chk("held_no_mem_req", 32'(bus.icache2mem_req_o), 32'd0);
        end
        bus.if2icache_req_i = 1'b0;
        @(negedge clk);
        chk("held_release", 32'(bus.icache2if_ack_o), 32'd0);

        // Conflict on index 0, then the evicted line misses again.
        fetch(32'h0000_2004, -1, -1, 1'b0, 1'b0);
        fetch(32'h0000_1004, -1, -1, 1'b0, 1'b0);

        // Flush during refill: another line and the refilled one both lose validity.
        fetch(32'h0000_1010, -1, -1, 1'b0, 1'b0);
        fetch(32'h0000_2008, 2, -1, 1'b0, 1'b0);
        fetch(32'h0000_1010, -1, -1, 1'b1, 1'b0);
        fetch(32'h0000_1004, -1, -1, 1'b1, 1'b0);

        // Withdrawn request: burst runs out, no ack, line is installed.
        fetch(32'h0000_4020, -1, 0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("withdrawn_no_ack", 32'(bus.icache2if_ack_o), 32'd0);
        end
        fetch(32'h0000_4024, -1, -1, 1'b0, 1'b0);

        // Flush coinciding with a hit: hit completes, then the line is gone.
        fetch(32'h0000_4028, -1, -1, 1'b0, 1'b1);
        fetch(32'h0000_4020, -1, -1, 1'b1, 1'b0);

        // Reset after beat 1 of a burst.
        bus.if2icache_req_i  = 1'b1;
        bus.if2icache_addr_i = 32'h0000_3008;
        @(negedge clk);
        chk("rstb_mem_req", 32'(bus.icache2mem_req_o), 32'd1);
        for (int b = 0; b < 2; b++) begin
            bus.mem2icache_ack_i    = 1'b1;
            bus.mem2icache_r_data_i = mem_val(32'h0000_3000 + 32'(4 * b));
            @(negedge clk);
        end
        bus.mem2icache_ack_i = 1'b0;
        bus.if2icache_req_i  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstb_mem_req_drop", 32'(bus.icache2mem_req_o), 32'd0);
        chk("rstb_ack", 32'(bus.icache2if_ack_o), 32'd0);
        rst_n = 1'b1;
        model_flush();
        @(negedge clk);
        fetch(32'h0000_4020, -1, -1, 1'b0, 1'b0);

        // Randomised traffic over a few conflicting tags.
        for (int n = 0; n < 60; n++) begin
            ra = ({$urandom_range(2), 8'h00} + 32'h10) << 8;
            ra = ra | ($urandom_range(15) << 4) | ($urandom_range(3) << 2) | $urandom_range(3);
            fb = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1;
            db = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1;
            if ($urandom_range(9) == 0) begin
                bus.icache_flush_i = 1'b1;
                @(negedge clk);
                bus.icache_flush_i = 1'b0;
                model_flush();
            end
            fetch(ra, fb, db, 1'b1, $urandom_range(9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule
